led_pulse_stretcher: RTL and testbench
======================================

Name: led_pulse_stretcher

Overview:
Output-side counterpart of the push-button input path. It takes single-cycle event pulses from the datapath and drives each board LED for a human-visible, fixed-length blink. Bursts of events are queued and shown as separate blinks, with a minimum dark gap between them. It sits between the datapath/FSM status pulses and the LED pins.

Parameters:
NUM_CH, 4, number of independent event/LED channels
CLK_DIV, 50000, Clock_50 cycles per 1 ms tick (50 MHz to 1 kHz); must be >= 2
ON_MS, 100, LED on-time per blink in ticks; must be >= 1
GAP_MS, 100, forced dark time after each blink in ticks; must be >= 1
PEND_MAX, 3, saturating depth of the per-channel pending-event counter; must be >= 1

Ports:
Clock_50  input  1  system clock, 50 MHz
Reset  input  1  synchronous, active-high reset
Event_pulse  input  NUM_CH  one-cycle request per channel; a level held N cycles counts as N events
Ovf_clear  input  NUM_CH  clears the matching Overflow bit
LED_out  output  NUM_CH  registered LED drive, 1 = lit
Busy  output  NUM_CH  1 when the channel is not IDLE or has pending events
Overflow  output  NUM_CH  sticky; set when an event is dropped at saturation

Behaviour:
- Reset is sampled on a Clock_50 edge. It forces every channel to IDLE, clears all counters, zeroes the divider, and drives LED_out, Busy and Overflow to 0. Reset mid-blink aborts the blink immediately, and pending events are lost.
- Divider: counts 0..CLK_DIV-1 and wraps. tick=1 for exactly one cycle, when count==CLK_DIV-1. The first tick after reset occurs at cycle CLK_DIV-1.
- Per-channel FSM: states IDLE, ON, GAP. Registers: ms counter of width clog2(max(ON_MS,GAP_MS)+1); pend of width clog2(PEND_MAX+1).
- IDLE with Event_pulse=1 at cycle t: state=ON and ms=ON_MS at t+1, and LED_out=1 from t+1. Latency is 1 cycle.
- ON: ms decrements in each cycle where tick=1.
  - A tick with ms==1 moves the channel to GAP with ms=GAP_MS, and LED_out=0 from the next cycle.
  - The ON duration is therefore exactly ON_MS ticks, i.e. between (ON_MS-1)*CLK_DIV+1 and ON_MS*CLK_DIV cycles.
- GAP: ms decrements on tick. A tick with ms==1 ends the gap:
  - if pend>0, go to ON, set ms=ON_MS, pend-1;
  - else go to IDLE.
- Event in ON or GAP: pend+1, saturating at PEND_MAX. An event arriving while pend==PEND_MAX is dropped and sets Overflow the next cycle.
- Simultaneous event and gap completion:
  - pend==0: go to ON and consume the event; pend stays 0; no overflow.
  - pend>0: go to ON and pend is unchanged (increment and decrement cancel); no overflow even at PEND_MAX.
- Ovf_clear and an overflow event in the same cycle: set wins, Overflow stays 1.
- Busy = (state!=IDLE) | (pend!=0), registered-state derived, no extra latency.
- Channels are fully independent. All channels share one tick.
- LED_out is driven directly from the state register (state==ON). There is no combinational path from any input to any output.

Decomposition:
- Package led_stretch_pkg holds:
  - the state enum (IDLE, ON, GAP) as a 2-bit typedef;
  - localparams for default CLK_DIV and ms values;
  - a function for counter width.
- Sub-module led_stretch_channel: one FSM plus ms and pend counters, taking tick as an input. The top instantiates NUM_CH of these in a generate loop and owns the single tick divider.

Test Plan:
Bench parameters: CLK_DIV=4, ON_MS=3, GAP_MS=2, PEND_MAX=3, NUM_CH=4.
1. Reset then a single Event_pulse[0] at cycle 10:
   - LED_out[0]=1 at cycle 11; ticks fall at 11, 15, 19; LED_out[0]=0 at 20.
   - Ticks at 23, 27 end GAP, and Busy[0]=0 from 28.
2. Burst: Event_pulse[1] high for 4 consecutive cycles starting in IDLE:
   - first event starts a blink, pend reaches 3, exactly 4 blinks are observed, and Overflow[1] stays 0.
3. Overflow: 6 one-cycle events on ch2 during ON:
   - pend saturates at 3, Overflow[2]=1 one cycle after the 4th dropped-candidate event, and exactly 4 blinks follow.
   - Ovf_clear[2] then clears it; Ovf_clear concurrent with a new dropped event leaves Overflow[2]=1.
4. Event on ch3 in the exact cycle its GAP completes with pend==0:
   - LED_out[3]=1 next cycle with no IDLE cycle and pend stays 0.
   - Repeat with pend=2: pend stays 2.
5. Assert Reset for one cycle mid-ON on ch0 with pend=2:
   - next cycle LED_out, Busy, Overflow are all 0, and no further blinks occur without new events.
6. Events on all 4 channels offset by 1 cycle:
   - each LED rises 1 cycle after its own event, and all fall on the same tick edge pattern relative to their own entry, with no cross-channel interaction.

Source files
------------

// File: rtl/led_stretch_pkg.sv
// Shared types and helpers for the LED pulse stretcher: channel state encoding,
// default timing values and a counter-width helper.
package led_stretch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } led_state_e;

  localparam int DEF_CLK_DIV  = 50000;
  localparam int DEF_ON_MS    = 100;
  localparam int DEF_GAP_MS   = 100;
  localparam int DEF_PEND_MAX = 3;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/led_stretch_channel.sv
// One LED channel: blink FSM with a ms down-counter, a saturating pending-event
// counter and a sticky overflow flag. Time advances only on the shared tick.
module led_stretch_channel
  import led_stretch_pkg::*;
#(
  parameter int ON_MS    = DEF_ON_MS,
  parameter int GAP_MS   = DEF_GAP_MS,
  parameter int PEND_MAX = DEF_PEND_MAX
) (
  input  logic Clock_50,
  input  logic Reset,
  input  logic tick,
  input  logic event_in,
  input  logic ovf_clear,
  output logic led,
  output logic busy,
  output logic overflow
);

  localparam int MS_MAX = (ON_MS > GAP_MS) ? ON_MS : GAP_MS;
  localparam int MS_W   = cnt_width(MS_MAX);
  localparam int PEND_W = cnt_width(PEND_MAX);

  localparam logic [MS_W-1:0]   MS_ON     = MS_W'(ON_MS);
  localparam logic [MS_W-1:0]   MS_GAP    = MS_W'(GAP_MS);
  localparam logic [MS_W-1:0]   MS_ONE    = MS_W'(1);
  localparam logic [PEND_W-1:0] PEND_FULL = PEND_W'(PEND_MAX);

  led_state_e        state, state_nxt;
  logic [MS_W-1:0]   ms, ms_nxt;
  logic [PEND_W-1:0] pend, pend_nxt;
  logic              ovf, ovf_nxt;
  logic              last_tick;
  logic              drop;

  always_ff @(posedge Clock_50) begin
    // NOTE: non-blocking so every register samples the pre-edge values of the others.
    if (Reset) begin
      state <= IDLE;
      ms    <= '0;
      pend  <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      ms    <= ms_nxt;
      pend  <= pend_nxt;
      ovf   <= ovf_nxt;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned, which would infer a latch.
    state_nxt = state;
    ms_nxt    = ms;
    pend_nxt  = pend;
    drop      = 1'b0;
    last_tick = tick && (ms == MS_ONE);

    case (state)
      IDLE: begin
        if (event_in) begin
          state_nxt = ON;
          ms_nxt    = MS_ON;
        end
      end

      ON: begin
        if (last_tick) begin
          state_nxt = GAP;
          ms_nxt    = MS_GAP;
        end else if (tick) begin
          ms_nxt = ms - MS_ONE;
        end
        if (event_in) begin
          if (pend == PEND_FULL) drop = 1'b1;
          else                   pend_nxt = pend + PEND_W'(1);
        end
      end

      GAP: begin
        if (last_tick) begin
          // An event landing on gap completion is consumed directly by the new blink.
          if (event_in || (pend != '0)) begin
            state_nxt = ON;
            ms_nxt    = MS_ON;
            if (!event_in) pend_nxt = pend - PEND_W'(1);
          end else begin
            state_nxt = IDLE;
            ms_nxt    = '0;
          end
        end else begin
          if (tick) ms_nxt = ms - MS_ONE;
          if (event_in) begin
            if (pend == PEND_FULL) drop = 1'b1;
            else                   pend_nxt = pend + PEND_W'(1);
          end
        end
      end

      default: begin
        state_nxt = IDLE;
        ms_nxt    = '0;
      end
    endcase

    ovf_nxt = drop | (ovf & ~ovf_clear);
  end

  always_comb begin
    led      = (state == ON);
    busy     = (state != IDLE) || (pend != '0);
    overflow = ovf;
  end

endmodule

// File: rtl/led_pulse_stretcher.sv
// Turns single-cycle event pulses into human-visible LED blinks, one channel
// per LED, all paced by a shared 1 ms tick divided down from Clock_50.
module led_pulse_stretcher
  import led_stretch_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int ON_MS    = DEF_ON_MS,
  parameter int GAP_MS   = DEF_GAP_MS,
  parameter int PEND_MAX = DEF_PEND_MAX
) (
  input  logic              Clock_50,
  input  logic              Reset,
  input  logic [NUM_CH-1:0] Event_pulse,
  input  logic [NUM_CH-1:0] Ovf_clear,
  output logic [NUM_CH-1:0] LED_out,
  output logic [NUM_CH-1:0] Busy,
  output logic [NUM_CH-1:0] Overflow
);

  localparam int DIV_W = cnt_width(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge Clock_50) begin
    if (Reset)     div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DIV_W'(1);
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    led_stretch_channel #(
      .ON_MS    (ON_MS),
      .GAP_MS   (GAP_MS),
      .PEND_MAX (PEND_MAX)
    ) u_ch (
      .Clock_50 (Clock_50),
      .Reset    (Reset),
      .tick     (tick),
      .event_in (Event_pulse[g]),
      .ovf_clear(Ovf_clear[g]),
      .led      (LED_out[g]),
      .busy     (Busy[g]),
      .overflow (Overflow[g])
    );
  end

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Bench for led_pulse_stretcher: directed scenarios plus random traffic, checked
// every cycle against a tick-budget model of each channel.
module tb_led_pulse_stretcher;

  localparam int NUM_CH   = 4;
  localparam int CLK_DIV  = 4;
  localparam int ON_MS    = 3;
  localparam int GAP_MS   = 2;
  localparam int PEND_MAX = 3;
  localparam int BLOCK    = ON_MS + GAP_MS;

  logic              Clock_50 = 1'b0;
  logic              Reset = 1'b1;
  logic [NUM_CH-1:0] Event_pulse = '0;
  logic [NUM_CH-1:0] Ovf_clear = '0;
  logic [NUM_CH-1:0] LED_out, Busy, Overflow;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 Clock_50 = ~Clock_50;

  led_pulse_stretcher #(
    .NUM_CH  (NUM_CH),
    .CLK_DIV (CLK_DIV),
    .ON_MS   (ON_MS),
    .GAP_MS  (GAP_MS),
    .PEND_MAX(PEND_MAX)
  ) dut (
    .Clock_50   (Clock_50),
    .Reset      (Reset),
    .Event_pulse(Event_pulse),
    .Ovf_clear  (Ovf_clear),
    .LED_out    (LED_out),
    .Busy       (Busy),
    .Overflow   (Overflow)
  );

  // Model: each channel owns a budget of ticks left in its current blink+gap
  // block; lit while more than GAP_MS ticks remain.
  int cyc = 0;
  int m_left[NUM_CH];
  int m_pend[NUM_CH];
  bit m_ovf[NUM_CH];
  bit tick_now, ev, drop;

  always @(posedge Clock_50) begin
    if (Reset) begin
      cyc = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_left[c] = 0;
        m_pend[c] = 0;
        m_ovf[c]  = 1'b0;
      end
    end else begin
      tick_now = ((cyc % CLK_DIV) == CLK_DIV - 1);
      for (int c = 0; c < NUM_CH; c++) begin
        ev   = Event_pulse[c];
        drop = 1'b0;
        if (m_left[c] == 0) begin
          if (ev) m_left[c] = BLOCK;
        end else if (tick_now && m_left[c] == 1) begin
          if (ev) m_left[c] = BLOCK;
          else if (m_pend[c] > 0) begin
            m_left[c] = BLOCK;
            m_pend[c] = m_pend[c] - 1;
          end else m_left[c] = 0;
        end else begin
          if (tick_now) m_left[c] = m_left[c] - 1;
          if (ev) begin
            if (m_pend[c] == PEND_MAX) drop = 1'b1;
            else m_pend[c] = m_pend[c] + 1;
          end
        end
        m_ovf[c] = drop ? 1'b1 : (Ovf_clear[c] ? 1'b0 : m_ovf[c]);
      end
      cyc = cyc + 1;
    end
  end

  function automatic logic [NUM_CH-1:0] exp_led();
    logic [NUM_CH-1:0] r;
    for (int c = 0; c < NUM_CH; c++) r[c] = (m_left[c] > GAP_MS);
    return r;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_busy();
    logic [NUM_CH-1:0] r;
    for (int c = 0; c < NUM_CH; c++) r[c] = (m_left[c] != 0) || (m_pend[c] != 0);
    return r;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_ovf();
    logic [NUM_CH-1:0] r;
    for (int c = 0; c < NUM_CH; c++) r[c] = m_ovf[c];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  int blinks[NUM_CH];
  logic [NUM_CH-1:0] led_prev = '0;

  always @(negedge Clock_50) begin
    if (cmp_en) begin
      check("led_model", LED_out, exp_led());
      check("busy_model", Busy, exp_busy());
      check("ovf_model", Overflow, exp_ovf());
      for (int c = 0; c < NUM_CH; c++)
        if (LED_out[c] && !led_prev[c]) blinks[c]++;
      led_prev = LED_out;
    end
  end

  task automatic wait_cycle(input int n);
    int guard = 0;
    while (cyc != n && guard < 1000) begin
      @(negedge Clock_50);
      guard++;
    end
    check("wait_cycle", cyc, n);
  endtask

  task automatic pulse(input logic [NUM_CH-1:0] mask, input int n);
    Event_pulse = mask;
    repeat (n) @(negedge Clock_50);
    Event_pulse = '0;
  endtask

  task automatic wait_idle(input int c);
    int guard = 0;
    while (Busy[c] && guard < 2000) begin
      @(negedge Clock_50);
      guard++;
    end
    check($sformatf("idle_timeout_ch%0d", c), Busy[c], 0);
  endtask

  // Stop on the negedge of a cycle whose tick completes channel c's gap.
  task automatic wait_gap_end(input int c);
    int guard = 0;
    while (!(m_left[c] == 1 && (cyc % CLK_DIV) == CLK_DIV - 1) && guard < 200) begin
      @(negedge Clock_50);
      guard++;
    end
    check($sformatf("gap_end_found_ch%0d", c), m_left[c], 1);
  endtask

  int base;

  initial begin
    repeat (2) @(negedge Clock_50);
    Reset  = 1'b0;
    cmp_en = 1'b1;
    check("rst_led", LED_out, 0);
    check("rst_busy", Busy, 0);
    check("rst_ovf", Overflow, 0);

    // Single blink with exact edge timing.
    wait_cycle(10);
    pulse(4'b0001, 1);
    check("t1_led_rise_c11", LED_out[0], 1);
    wait_cycle(19);
    check("t1_led_on_c19", LED_out[0], 1);
    wait_cycle(20);
    check("t1_led_off_c20", LED_out[0], 0);
    wait_cycle(27);
    check("t1_busy_c27", Busy[0], 1);
    wait_cycle(28);
    check("t1_busy_off_c28", Busy[0], 0);

    // Burst of four held events: four blinks, no overflow.
    base = blinks[1];
    pulse(4'b0010, 4);
    check("t2_pend_full", m_pend[1], 3);
    wait_idle(1);
    check("t2_blinks", blinks[1] - base, 4);
    check("t2_no_ovf", Overflow[1], 0);

    // Overflow on ch2.
    base = blinks[2];
    Event_pulse = 4'b0100;
    @(negedge Clock_50);
    for (int i = 0; i < 6; i++) begin
      Event_pulse = 4'b0100;
      @(negedge Clock_50);
      if (i == 2) check("t3_ovf_pre", Overflow[2], 0);
      if (i == 3) check("t3_ovf_set", Overflow[2], 1);
    end
    Event_pulse = '0;
    wait_idle(2);
    check("t3_blinks", blinks[2] - base, 4);
    check("t3_ovf_sticky", Overflow[2], 1);
    Ovf_clear = 4'b0100;
    @(negedge Clock_50);
    Ovf_clear = '0;
    check("t3_ovf_cleared", Overflow[2], 0);
    pulse(4'b0100, 5);
    Event_pulse = 4'b0100;
    Ovf_clear   = 4'b0100;
    @(negedge Clock_50);
    Event_pulse = '0;
    check("t3_set_wins", Overflow[2], 1);
    @(negedge Clock_50);
    Ovf_clear = '0;
    check("t3_clear_alone", Overflow[2], 0);
    wait_idle(2);

    // Event exactly on gap completion, pend 0 then pend 2.
    base = blinks[3];
    pulse(4'b1000, 1);
    wait_gap_end(3);
    pulse(4'b1000, 1);
    check("t4_led_direct", LED_out[3], 1);
    check("t4_pend0", m_pend[3], 0);
    wait_idle(3);
    check("t4_blinks_a", blinks[3] - base, 2);
    base = blinks[3];
    pulse(4'b1000, 3);
    wait_gap_end(3);
    pulse(4'b1000, 1);
    check("t4_led_direct_p2", LED_out[3], 1);
    check("t4_pend2", m_pend[3], 2);
    wait_idle(3);
    check("t4_blinks_b", blinks[3] - base, 4);

    // Reset mid-blink with pending events.
    pulse(4'b0001, 3);
    check("t5_on_before", LED_out[0], 1);
    Reset = 1'b1;
    @(negedge Clock_50);
    Reset = 1'b0;
    check("t5_led", LED_out, 0);
    check("t5_busy", Busy, 0);
    check("t5_ovf", Overflow, 0);
    base = blinks[0];
    repeat (80) @(negedge Clock_50);
    check("t5_no_blinks", blinks[0] - base, 0);

    // Staggered events across all channels.
    for (int c = 0; c < NUM_CH; c++) begin
      check($sformatf("t6_pre%0d", c), LED_out[c], 0);
      Event_pulse = NUM_CH'(1) << c;
      @(negedge Clock_50);
      check($sformatf("t6_rise%0d", c), LED_out[c], 1);
    end
    Event_pulse = '0;
    for (int c = 0; c < NUM_CH; c++) wait_idle(c);

    // Random traffic, including occasional resets.
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        Event_pulse[c] = ($urandom_range(0, 7) == 0);
        Ovf_clear[c]   = ($urandom_range(0, 31) == 0);
      end
      Reset = ($urandom_range(0, 999) == 0);
      @(negedge Clock_50);
    end
    Event_pulse = '0;
    Ovf_clear   = '0;
    Reset       = 1'b0;
    for (int c = 0; c < NUM_CH; c++) wait_idle(c);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
